// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next search start after a release; a 3-bit add wraps 7 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/tree2eightDecoder.sv
// 3-to-8 one-hot decoder built as a binary tree of enables (1 -> 2 -> 4 -> 8).
module tree2eightDecoder (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] out
);

  logic [1:0] lvl1;
  logic [3:0] lvl2;

  // Stage 1: split on the MSB.
  assign lvl1[0] = en & ~sel[2];
  assign lvl1[1] = en &  sel[2];

  // Stage 2: split each branch on the middle bit.
  assign lvl2[0] = lvl1[0] & ~sel[1];
  assign lvl2[1] = lvl1[0] &  sel[1];
  assign lvl2[2] = lvl1[1] & ~sel[1];
  assign lvl2[3] = lvl1[1] &  sel[1];

  // Stage 3: split each branch on the LSB.
  assign out[0] = lvl2[0] & ~sel[0];
  assign out[1] = lvl2[0] &  sel[0];
  assign out[2] = lvl2[1] & ~sel[0];
  assign out[3] = lvl2[1] &  sel[0];
  assign out[4] = lvl2[2] & ~sel[0];
  assign out[5] = lvl2[2] &  sel[0];
  assign out[6] = lvl2[3] & ~sel[0];
  assign out[7] = lvl2[3] &  sel[0];

endmodule

// File: rtl/rr_arb8_ctrl.sv
// 8-requester round-robin arbiter with a bounded hold time per grant.
// A grant lasts until done, a drop of the owner's request, or MAX_HOLD cycles,
// and is always followed by at least one idle cycle.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hcnt;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_hit;
  logic [IDX_W-1:0] cand;
  logic             rel_normal;
  logic             rel_force;

  // Priority search: first set request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr + i[IDX_W-1:0];
      if (!sel_hit && req[cand]) begin
        sel_idx = cand;
        sel_hit = 1'b1;
      end
    end
  end

  // Release decode; a voluntary release masks a coincident hold expiry.
  always_comb begin
    rel_normal = done || !req[gnt_idx];
    rel_force  = !rel_normal && (hcnt == HOLD_LAST);
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      hcnt    <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_hit) begin
            state   <= GRANT;
            gnt_idx <= sel_idx;
            gnt_vld <= 1'b1;
            hcnt    <= '0;
          end
        end
        GRANT: begin
          if (rel_normal || rel_force) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            ptr     <= next_idx(gnt_idx);
            hcnt    <= '0;
            timeout <= rel_force;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tree2eightDecoder u_dec (
    .sel (gnt_idx),
    .en  (gnt_vld),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: two instances (MAX_HOLD 16 and 4) share stimulus and
// are each compared every cycle against a behavioural arbiter model, with
// literal expectations from the directed scenarios pinning the model.
module tb_rr_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt0, gnt1;
  logic [2:0] idx0, idx1;
  logic       vld0, vld1;
  logic       tmo0, tmo1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rr_arb8_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_vld(vld0), .timeout(tmo0)
  );

  rr_arb8_ctrl #(.MAX_HOLD(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_vld(vld1), .timeout(tmo1)
  );

  // Model: owner = -1 when idle; held = number of grant cycles so far.
  int m_owner [2];
  int m_ptr   [2];
  int m_held  [2];
  bit m_tmo   [2];
  int maxh    [2] = '{16, 4};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_owner[d] = -1;
        m_ptr[d]   = 0;
        m_held[d]  = 0;
        m_tmo[d]   = 1'b0;
      end else if (m_owner[d] < 0) begin
        m_tmo[d] = 1'b0;
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr[d] + k) % 8;
          if (m_owner[d] < 0 && req[c]) begin
            m_owner[d] = c;
            m_held[d]  = 1;
          end
        end
      end else begin
        m_tmo[d] = 1'b0;
        if (done || !req[m_owner[d]]) begin
          m_ptr[d]   = (m_owner[d] + 1) % 8;
          m_owner[d] = -1;
        end else if (m_held[d] == maxh[d]) begin
          m_ptr[d]   = (m_owner[d] + 1) % 8;
          m_owner[d] = -1;
          m_tmo[d]   = 1'b1;
        end else begin
          m_held[d] = m_held[d] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_gnt(input int d);
    return (m_owner[d] < 0) ? 0 : (1 << m_owner[d]);
  endfunction

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_gnt", int'(gnt0), exp_gnt(0));
      check("m0_idx", int'(idx0), (m_owner[0] < 0) ? 0 : m_owner[0]);
      check("m0_vld", int'(vld0), int'(m_owner[0] >= 0));
      check("m0_tmo", int'(tmo0), int'(m_tmo[0]));
      check("m1_gnt", int'(gnt1), exp_gnt(1));
      check("m1_idx", int'(idx1), (m_owner[1] < 0) ? 0 : m_owner[1]);
      check("m1_vld", int'(vld1), int'(m_owner[1] >= 0));
      check("m1_tmo", int'(tmo1), int'(m_tmo[1]));
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_gnt", int'(gnt0), 0);
    check("rst_vld", int'(vld0), 0);
    check("rst_tmo", int'(tmo0), 0);
    rst_n = 1'b1;

    // Single requester, done after 3 granted cycles.
    req = 8'h01;
    @(negedge clk); check("r28_g1", int'(gnt0), 8'h01);
    @(negedge clk); check("r28_g2", int'(gnt0), 8'h01);
    @(negedge clk); check("r28_g3", int'(gnt0), 8'h01);
    done = 1'b1; req = 8'h00;
    @(negedge clk); check("r28_rel", int'(gnt0), 8'h00);
    done = 1'b0; req = 8'h03;
    @(negedge clk); check("r28_ptr1", int'(gnt0), 8'h02);
    done = 1'b1;
    @(negedge clk); check("r28_gap", int'(vld0), 0);
    done = 1'b0;
    @(negedge clk); check("r28_wrap", int'(gnt0), 8'h01);
    done = 1'b1; req = 8'h00;
    @(negedge clk); done = 1'b0;

    // Done in idle is ignored.
    done = 1'b1;
    repeat (2) @(negedge clk);
    check("r21_idle", int'(vld0), 0);
    done = 1'b0;

    // All requesting, release each grant: order 0..7,0 from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("r29_order", int'(gnt0), 1 << (k % 8));
      done = 1'b1;
      @(negedge clk);
      check("r29_gap", int'(gnt0), 0);
      done = 1'b0;
    end
    req = 8'h00;
    @(negedge clk);

    // ptr is 1; grant index 6 to move ptr to 7, then 0x81 -> 7 before 0.
    req = 8'h40;
    @(negedge clk); check("r30_pre", int'(gnt0), 8'h40);
    done = 1'b1;
    @(negedge clk); done = 1'b0; req = 8'h81;
    @(negedge clk); check("r30_first", int'(gnt0), 8'h80);
    done = 1'b1;
    @(negedge clk); check("r30_gap", int'(gnt0), 0);
    done = 1'b0;
    @(negedge clk); check("r30_second", int'(gnt0), 8'h01);
    done = 1'b1; req = 8'h00;
    @(negedge clk); done = 1'b0;

    // Hold expiry on the MAX_HOLD=4 instance.
    req = 8'h04;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("r31_hold", int'(gnt1), 8'h04);
    end
    @(negedge clk);
    check("r31_tmo", int'(tmo1), 1);
    check("r31_drop", int'(gnt1), 0);
    check("r31_dut0", int'(gnt0), 8'h04);
    @(negedge clk);
    check("r31_regnt", int'(gnt1), 8'h04);
    check("r31_tmo_end", int'(tmo1), 0);
    req = 8'h00;
    @(negedge clk);

    // done coinciding with hold expiry is a normal release.
    req = 8'h02;
    repeat (4) @(negedge clk);
    check("r19_held", int'(gnt1), 8'h02);
    done = 1'b1;
    @(negedge clk);
    check("r19_tmo", int'(tmo1), 0);
    check("r19_drop", int'(gnt1), 0);
    done = 1'b0; req = 8'h00;
    @(negedge clk);

    // Owner 5 drops its request while 6 is waiting.
    req = 8'h20;
    @(negedge clk); check("r32_own5", int'(gnt0), 8'h20);
    req = 8'h40;
    @(negedge clk); check("r32_drop", int'(gnt0), 0);
    @(negedge clk); check("r32_own6", int'(gnt0), 8'h40);
    done = 1'b1;
    @(negedge clk); done = 1'b0; req = 8'h00;
    @(negedge clk);

    // Reset in the middle of a grant to index 3.
    req = 8'h08;
    @(negedge clk); check("r33_own3", int'(gnt0), 8'h08);
    rst_n = 1'b0;
    @(negedge clk);
    check("r33_rgnt", int'(gnt0), 0);
    check("r33_rvld", int'(vld0), 0);
    check("r33_rtmo", int'(tmo0), 0);
    rst_n = 1'b1; req = 8'h18;
    @(negedge clk);
    check("r33_first", int'(gnt0), 8'h08);
    check("r33_idx", int'(idx0), 3);
    done = 1'b1; req = 8'h00;
    @(negedge clk); done = 1'b0;

    // Mixed traffic, checked by the model alone.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done  = ($urandom_range(0, 4) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1; req = 8'h00; done = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctrl.md
RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles one requester keeps the grant (range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port req, input, 8: request per requester, level-held while wanting the shared resource.
REQ-005 SHALL have port done, input, 1: current owner releases the grant this cycle.
REQ-006 SHALL have port gnt, output, 8: one-hot grant, all-zero when idle.
REQ-007 SHALL have port gnt_idx, output, 3: binary index of current owner, 0 when idle.
REQ-008 SHALL have port gnt_vld, output, 1: high while any grant is asserted.
REQ-009 SHALL have port timeout, output, 1: one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-010 SHALL implement FSM states IDLE and GRANT, plus a 3-bit round-robin pointer ptr and a hold counter hcnt.
REQ-011 In IDLE with req != 0, SHALL select the first set req bit at or after ptr, searching upward with wrap 7->0, and enter GRANT at the next edge.
REQ-012 SHALL register gnt, gnt_idx, and gnt_vld so that they assert exactly one cycle after req is sampled in IDLE.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE with all outputs 0.
REQ-014 In GRANT, SHALL hold gnt/gnt_idx constant, ignoring changes on other req bits.
REQ-015 In GRANT, SHALL release when done=1 or req[gnt_idx]=0: outputs go to 0 and state goes to IDLE at the next edge.
REQ-016 hcnt SHALL clear on entry to GRANT and increment each GRANT cycle; when hcnt = MAX_HOLD-1 without release, SHALL force release with timeout=1 for one cycle coincident with gnt dropping.
REQ-017 On any release (done, req drop, or timeout), SHALL set ptr = gnt_idx+1 mod 8 (7 wraps to 0).
REQ-018 SHALL keep at least one IDLE cycle between consecutive grants; gnt_vld low for exactly one cycle when req remains pending.
REQ-019 If done and a timeout condition coincide, SHALL treat the event as a normal release with timeout=0.
REQ-020 gnt SHALL always equal the one-hot decode of gnt_idx when gnt_vld=1, and never have more than one bit set.
REQ-021 done asserted in IDLE SHALL be ignored.

Reset
REQ-022 When rst_n=0 at a rising edge, SHALL set state=IDLE, ptr=0, hcnt=0, gnt=0, gnt_idx=0, gnt_vld=0, and timeout=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant at that edge with no timeout pulse and no ptr advance beyond 0.
REQ-024 After rst_n returns high, the first arbitration SHALL search from index 0.

Structure
REQ-025 SHALL place the state enum (IDLE, GRANT) and the requester count constant (8) in shared package arb_pkg.
REQ-026 SHALL generate gnt from gnt_idx through one sub-module, the existing 3-to-8 decoder tree2eightDecoder, gated by gnt_vld.
REQ-027 The priority search SHALL be combinational logic within rr_arb8_ctrl; total RTL of 120-400 lines.

Verification
REQ-028 Reset, then req=8'h01, done after 3 granted cycles -> gnt=8'h01 one cycle after req, held 3 cycles, then gnt=0, ptr=1.
REQ-029 req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0 with one idle cycle between grants (wrap check).
REQ-030 req=8'h81 with ptr=7 -> gnt=8'h80 first; after release -> gnt=8'h01.
REQ-031 MAX_HOLD=4, req=8'h04 held, no done -> gnt=8'h04 for 4 cycles, timeout pulse on the 4th cycle edge, ptr=3, then regrant of 8'h04 after one idle cycle.
REQ-032 Owner 5 drops req[5] while req[6] is set -> gnt=0 next edge, then gnt=8'h40 one cycle later.
REQ-033 rst_n=0 during grant of index 3 -> all outputs 0 at that edge; after reset, with req=8'h18, first grant goes to index 3.
